// File: rtl/bin_to_gray_stream.sv
// Streaming binary-to-Gray encoder with a 2-entry skid buffer and a successor flag.
// Optional gray_par output is enabled by defining BIN_TO_GRAY_PARITY_EN.
module bin_to_gray_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] bin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_step,
  output logic [15:0]      xfer_cnt
`ifdef BIN_TO_GRAY_PARITY_EN
  ,
  output logic             gray_par
`endif
);

  // Stored word layout, LSB first: gray, step flag, then parity when enabled.
`ifdef BIN_TO_GRAY_PARITY_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [PW-1:0]    out_word_q, out_word_d;
  logic [PW-1:0]    skid_word_q, skid_word_d;
  logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
  logic             prev_vld_q, prev_vld_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;

  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] enc_gray;
  logic             enc_step;
  logic [PW-1:0]    enc_word;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  assign accept   = in_valid & in_ready_q;
  assign xfer     = (state_q != S_EMPTY) & out_ready;
  assign enc_gray = to_gray(bin_in);
  // Width-exact successor compare: the add wraps naturally at 2^WIDTH.
  assign enc_step = prev_vld_q && (bin_in == prev_bin_q + WIDTH'(1));

`ifdef BIN_TO_GRAY_PARITY_EN
  assign enc_word = {bin_in[0], enc_step, enc_gray};
  assign gray_par = out_word_q[WIDTH+1];
`else
  assign enc_word = {enc_step, enc_gray};
`endif

  always_comb begin
    state_d     = state_q;
    out_word_d  = out_word_q;
    skid_word_d = skid_word_q;
    prev_bin_d  = prev_bin_q;
    prev_vld_d  = prev_vld_q;
    xfer_cnt_d  = xfer ? xfer_cnt_q + 16'd1 : xfer_cnt_q;

    if (accept) begin
      prev_bin_d = bin_in;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          out_word_d = enc_word;
          state_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && xfer) begin
          out_word_d = enc_word;
        end else if (accept) begin
          skid_word_d = enc_word;
          state_d     = S_TWO;
        end else if (xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (xfer) begin
          out_word_d = skid_word_q;
          state_d    = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_word_q  <= '0;
      skid_word_q <= '0;
      prev_bin_q  <= '0;
      prev_vld_q  <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_word_q  <= out_word_d;
      skid_word_q <= skid_word_d;
      prev_bin_q  <= prev_bin_d;
      prev_vld_q  <= prev_vld_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign gray_out  = out_word_q[WIDTH-1:0];
  assign out_step  = out_word_q[WIDTH];
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_bin_to_gray_stream.sv
// Bench for bin_to_gray_stream: a WIDTH=4 and a WIDTH=8 instance checked against a queue model.
module tb_bin_to_gray_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       in_valid, out_ready;
  logic [7:0] bin;

  logic       in_ready4, out_valid4, out_step4;
  logic [3:0] gray4;
  logic [15:0] cnt4;
  logic       in_ready8, out_valid8, out_step8;
  logic [7:0] gray8;
  logic [15:0] cnt8;
`ifdef BIN_TO_GRAY_PARITY_EN
  logic       par4, par8;
`endif

  bin_to_gray_stream #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_ready(in_ready4), .bin_in(bin[3:0]),
    .out_valid(out_valid4), .out_ready(out_ready & ~sel),
    .gray_out(gray4), .out_step(out_step4), .xfer_cnt(cnt4)
`ifdef BIN_TO_GRAY_PARITY_EN
    , .gray_par(par4)
`endif
  );

  bin_to_gray_stream #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_ready(in_ready8), .bin_in(bin),
    .out_valid(out_valid8), .out_ready(out_ready & sel),
    .gray_out(gray8), .out_step(out_step8), .xfer_cnt(cnt8)
`ifdef BIN_TO_GRAY_PARITY_EN
    , .gray_par(par8)
`endif
  );

  logic        o_ir, o_ov, o_st, o_par;
  logic [7:0]  o_g;
  logic [15:0] o_cnt;
  logic [7:0]  wmask;

  always_comb begin
    wmask = sel ? 8'hFF : 8'h0F;
    if (sel) begin
      o_ir = in_ready8; o_ov = out_valid8; o_g = gray8; o_st = out_step8; o_cnt = cnt8;
    end else begin
      o_ir = in_ready4; o_ov = out_valid4; o_g = {4'h0, gray4}; o_st = out_step4; o_cnt = cnt4;
    end
`ifdef BIN_TO_GRAY_PARITY_EN
    o_par = sel ? par8 : par4;
`else
    o_par = 1'b0;
`endif
  end

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       step;
    logic       par;
  } ent_t;

  ent_t        q[$];
  ent_t        dut_log[$];
  logic [7:0]  prev_b;
  logic        prev_v;
  logic [15:0] e_cnt;
  logic [27:0] obs_vec, exp_vec;
  logic [7:0]  obs_g;
  logic        acc, xfr;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    dut_log.delete();
    prev_v = 1'b0;
    prev_b = 8'h0;
    e_cnt  = 16'h0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; bin = 8'h0;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // One clock: drive, sample at negedge, predict accept/transfer, then advance the model.
  task automatic cycle(input logic iv, input logic [7:0] b, input logic ordy);
    ent_t e, o;
    logic [7:0] bm;
    in_valid = iv; bin = b; out_ready = ordy;
    bm = b & wmask;
    @(negedge clk);
    obs_g   = o_g;
    obs_vec = {o_ir, o_ov, (o_ov ? {o_g, o_st, o_par} : 10'h0), o_cnt};
    exp_vec = {(q.size() < 2), (q.size() > 0),
               ((q.size() > 0) ? {q[0].gray, q[0].step, q[0].par} : 10'h0), e_cnt};
    acc = iv && (q.size() < 2);
    xfr = ordy && (q.size() > 0);
    if (xfr) begin
      o.bin = q[0].bin; o.gray = o_g; o.step = o_st; o.par = o_par;
    end
    @(posedge clk); #1;
    if (xfr) begin
      void'(q.pop_front());
      dut_log.push_back(o);
      e_cnt = e_cnt + 16'd1;
    end
    if (acc) begin
      e.bin  = bm;
      e.gray = bm ^ (bm >> 1);
      e.step = prev_v && (((prev_b + 8'd1) & wmask) == bm);
`ifdef BIN_TO_GRAY_PARITY_EN
      e.par  = bm[0];
`else
      e.par  = 1'b0;
`endif
      q.push_back(e);
      prev_b = bm;
      prev_v = 1'b1;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    vectors++;
    if ({in_ready4, out_valid4, gray4, out_step4, cnt4} !== {1'b1, 1'b0, 4'h0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_w4: got %h expected %h", {in_ready4, out_valid4, gray4, out_step4, cnt4},
               {1'b1, 1'b0, 4'h0, 1'b0, 16'h0});
    end
    vectors++;
    if ({in_ready8, out_valid8, gray8, out_step8, cnt8} !== {1'b1, 1'b0, 8'h0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_w8: got %h expected %h", {in_ready8, out_valid8, gray8, out_step8, cnt8},
               {1'b1, 1'b0, 8'h0, 1'b0, 16'h0});
    end
`ifdef BIN_TO_GRAY_PARITY_EN
    vectors++;
    if ({par4, par8} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_par: got %b expected 00", {par4, par8});
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[4]  = '{8'd5, 8'd8, 8'd15, 8'd0};
    logic [7:0] exp_g[4] = '{8'h07, 8'h0C, 8'h08, 8'h00};
    logic       exp_s[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(i < 4, (i < 4) ? vals[i & 3] : 8'h0, 1'b1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (dut_log.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected 4", dut_log.size());
    end
    for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
      vectors++;
      if ({dut_log[i].gray, dut_log[i].step} !== {exp_g[i], exp_s[i]}) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got %h expected %h", i, {dut_log[i].gray, dut_log[i].step},
                 {exp_g[i], exp_s[i]});
      end
    end
    @(negedge clk);
    vectors++;
    if (o_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL b2b_xfer_cnt: got %0d expected 4", o_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] vals[4]  = '{8'd3, 8'd4, 8'd5, 8'd6};
    logic [7:0] exp_g[4] = '{8'h02, 8'h06, 8'h07, 8'h05};
    logic       exp_s[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int idx = 0;
    sel = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, (q.size() < 2) ? vals[idx & 3] : 8'($urandom), 1'b0);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL bp_stall%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (acc) idx++;
    end
    vectors++;
    if (idx != 2) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d expected 2", idx);
    end
    for (int c = 0; c < 20 && dut_log.size() < 4; c++) begin
      cycle(idx < 4, (idx < 4 && q.size() < 2) ? vals[idx & 3] : 8'($urandom), 1'b1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL bp_drain%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (acc) idx++;
    end
    vectors++;
    if (dut_log.size() != 4) begin
      miscompares++;
      $display("FAIL bp_count: got %0d expected 4", dut_log.size());
    end
    for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
      vectors++;
      if ({dut_log[i].gray, dut_log[i].step} !== {exp_g[i], exp_s[i]}) begin
        miscompares++;
        $display("FAIL bp_word%0d: got %h expected %h", i, {dut_log[i].gray, dut_log[i].step},
                 {exp_g[i], exp_s[i]});
      end
    end
  endtask

  task automatic test_random_stream();
    int   nxt = 0;
    logic was_stall = 1'b0;
    logic [7:0] last_g = 8'h0;
    logic ordy;
    sel = 1'b1;
    do_reset();
    for (int c = 0; c < 3000 && (nxt < 256 || q.size() > 0); c++) begin
      ordy = 1'($urandom_range(0, 1));
      cycle((nxt < 256) && ($urandom_range(0, 3) != 0), 8'(nxt), ordy);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL rnd_cycle%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (was_stall) begin
        vectors++;
        if (obs_g !== last_g) begin
          miscompares++;
          $display("FAIL rnd_stall_hold%0d: got %h expected %h", c, obs_g, last_g);
        end
      end
      was_stall = obs_vec[26] && !ordy;
      last_g    = obs_g;
      if (acc) nxt++;
    end
    vectors++;
    if (dut_log.size() != 256) begin
      miscompares++;
      $display("FAIL rnd_count: got %0d expected 256", dut_log.size());
    end
    for (int i = 0; i < 256 && i < dut_log.size(); i++) begin
      vectors++;
      if ({g2b(dut_log[i].gray), dut_log[i].step} !== {8'(i), (i != 0)}) begin
        miscompares++;
        $display("FAIL rnd_decode%0d: got %h expected %h", i, {g2b(dut_log[i].gray), dut_log[i].step},
                 {8'(i), (i != 0)});
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    cycle(1'b1, 8'd1, 1'b1);
    cycle(1'b1, 8'd2, 1'b1);
    cycle(1'b1, 8'd5, 1'b1);
    cycle(1'b1, 8'd6, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if ({out_valid4, in_ready4, cnt4} !== {1'b1, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL mid_pre_reset: got %h expected %h", {out_valid4, in_ready4, cnt4}, {1'b1, 1'b0, 16'd2});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid4, in_ready4, gray4, out_step4, cnt4} !== {1'b0, 1'b1, 4'h0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL mid_async_reset: got %h expected %h", {out_valid4, in_ready4, gray4, out_step4, cnt4},
               {1'b0, 1'b1, 4'h0, 1'b0, 16'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cycle(1'b1, 8'd7, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL mid_post_accept: got %h expected %h", obs_vec, exp_vec);
    end
    cycle(1'b0, 8'd0, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL mid_post_out: got %h expected %h", obs_vec, exp_vec);
    end
    vectors++;
    if (dut_log.size() != 1 || {dut_log[0].gray, dut_log[0].step} !== {8'h04, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_first_word: got %0d words, first %h expected 1 words, first %h",
               dut_log.size(), (dut_log.size() > 0) ? {dut_log[0].gray, dut_log[0].step} : 9'h0, {8'h04, 1'b0});
    end
  endtask

  task automatic test_repeat();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(i < 2, 8'd9, 1'b1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL rep_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (dut_log.size() != 2) begin
      miscompares++;
      $display("FAIL rep_count: got %0d expected 2", dut_log.size());
    end
    for (int i = 0; i < 2 && i < dut_log.size(); i++) begin
      vectors++;
      if ({dut_log[i].gray, dut_log[i].step} !== {8'h0D, 1'b0}) begin
        miscompares++;
        $display("FAIL rep_word%0d: got %h expected %h", i, {dut_log[i].gray, dut_log[i].step}, {8'h0D, 1'b0});
      end
    end
  endtask

`ifdef BIN_TO_GRAY_PARITY_EN
  task automatic test_parity();
    sel = 1'b0;
    do_reset();
    cycle(1'b1, 8'd5, 1'b1);
    cycle(1'b1, 8'd8, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    vectors++;
    if (dut_log.size() != 2 || {dut_log[0].par, dut_log[1].par} !== 2'b10) begin
      miscompares++;
      $display("FAIL parity: got %0d words, pars %b expected 2 words, pars 10", dut_log.size(),
               (dut_log.size() == 2) ? {dut_log[0].par, dut_log[1].par} : 2'b00);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; bin = 8'h0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_mid();
    test_repeat();
`ifdef BIN_TO_GRAY_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
